sumsq_acc: RTL and testbench
============================

SUMSQ_ACC -- requirements
Module: sumsq_acc

Interface
REQ-001 SHALL have parameter W, default 12: unsigned input sample width per channel.
REQ-002 SHALL have parameter N, default 4: number of channels, N >= 1.
REQ-003 SHALL have parameter LEN_W, default 8: window-length field width.
REQ-004 SHALL have localparam OUT_W = 2*W + $clog2(N) + LEN_W: output width, no overflow possible.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  in_data holds a valid sample vector.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port in_data  input  N*W  channel k in bits [k*W +: W], unsigned.
REQ-010 SHALL have port win_len  input  LEN_W  samples per output window; 0 treated as 1.
REQ-011 SHALL have port out_valid  output  1  out_data holds a completed window result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port out_data  output  OUT_W  sum of squares over all channels and window samples.

Function
REQ-014 SHALL compute, per accepted sample, S = sum over k of in_data[k]^2, full precision, unsigned.
REQ-015 SHALL pipeline in three register stages: stage1 = N squares (2W bits each) plus valid bit; stage2 = adder-tree sum S plus valid bit; stage3 = accumulator / output register.
REQ-016 SHALL define the global advance enable en = !out_valid || out_ready; in_ready = en.
REQ-017 SHALL accept a sample only on a rising edge where in_valid && in_ready; when en = 0, every stage holds, including valid bits.
REQ-018 SHALL, while en = 1, let pipeline bubbles (in_valid = 0) propagate as invalid stages, which do not change the accumulator or counter.
REQ-019 SHALL keep a sample counter cnt (LEN_W bits) and an accumulator acc (OUT_W bits).
REQ-020 SHALL latch win_len into len_q (0 mapped to 1) when a valid stage2 value enters stage3 with cnt = 0; changes to win_len mid-window SHALL be ignored.
REQ-021 SHALL, on a valid stage2 entry with en = 1, form a_next = (cnt == 0 ? 0 : acc) + S.
REQ-022 SHALL, if cnt + 1 == effective length, load out_data <= a_next, set out_valid <= 1 and cnt <= 0; otherwise set acc <= a_next and cnt <= cnt + 1.
REQ-023 SHALL clear out_valid on an out_valid && out_ready edge unless a new result loads on the same edge, in which case out_valid stays 1 with the new data.
REQ-024 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL, with win_len = 1 and no stall, drive out_valid high with the result immediately after the 2nd rising edge following the accepting edge, sustaining 1 result per cycle.
REQ-026 SHALL have maximum window 2^LEN_W - 1 samples; OUT_W guarantees no wrap.

Reset
REQ-027 SHALL, when rstn = 0 at a rising edge, clear all stage valid bits, cnt, acc, len_q, out_valid (0) and out_data (0); in_ready = 1 in the following cycle.
REQ-028 SHALL discard in-flight samples and partial windows on reset mid-operation; no output is produced for them.

Verification
REQ-029 SHALL verify: N=4, W=12, win_len=1, all channels 4095, out_ready=1 -> out_data = 67076100, out_valid two edges after acceptance.
REQ-030 SHALL verify: win_len=3, three samples each (1,2,3,4) -> single result 90 after the third sample; no out_valid for samples 1-2.
REQ-031 SHALL verify: win_len=1, out_ready=0 for 5 cycles with a result pending -> in_ready=0, out_data held; on release, results are delivered in order with none lost or duplicated.
REQ-032 SHALL verify: win_len=0, sample (0,0,0,5) -> out_data = 25, behaving as window 1.
REQ-033 SHALL verify: win_len=4, two samples accepted, then rstn low 1 cycle, then 4 samples of (1,1,1,1) -> single result 16.
REQ-034 SHALL verify: win_len changed from 2 to 5 after the first sample of a window -> that window closes after 2 samples; the next window uses 5.

Source files
------------

// File: rtl/sumsq_acc.sv
// Windowed sum-of-squares accumulator: squares N unsigned channels per sample, sums them,
// and accumulates over a programmable window with a valid/ready output handshake.
module sumsq_acc #(
    parameter  int W     = 12,
    parameter  int N     = 4,
    parameter  int LEN_W = 8,
    localparam int OUT_W = 2*W + $clog2(N) + LEN_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic [LEN_W-1:0]   win_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data
);

    localparam int SQ_W  = 2*W;
    localparam int SUM_W = SQ_W + $clog2(N);
    localparam int NP    = 1 << $clog2(N);

    logic               w_en;
    logic [SQ_W-1:0]    w_sq [N];
    logic [SQ_W-1:0]    r_sq [N];
    logic               r_v1;
    logic [SUM_W-1:0]   w_tree [1:2*NP-1];
    logic [SUM_W-1:0]   r_sum;
    logic               r_v2;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len_q;
    logic [LEN_W-1:0]   w_len_in;
    logic [LEN_W-1:0]   w_len_eff;
    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   w_a_next;
    logic               w_last;
    logic               w_load;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;

    // One enable for the whole pipe: everything freezes while a result waits unaccepted.
    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    for (genvar k = 0; k < N; k++) begin : g_sq
        logic [SQ_W-1:0] w_x;
        assign w_x     = {{W{1'b0}}, in_data[k*W +: W]};
        assign w_sq[k] = w_x * w_x;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < N; k++) r_sq[k] <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < N; k++) r_sq[k] <= w_sq[k];
            end
        end
    end

    // Heap-indexed binary adder tree: leaves at NP..2*NP-1, root at index 1.
    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < N) begin : g_used
            assign w_tree[NP+i] = SUM_W'(r_sq[i]);
        end else begin : g_pad
            assign w_tree[NP+i] = '0;
        end
    end

    for (genvar i = 1; i < NP; i++) begin : g_node
        assign w_tree[i] = w_tree[2*i] + w_tree[2*i+1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v2  <= 1'b0;
            r_sum <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            if (r_v1) r_sum <= w_tree[1];
        end
    end

    // The window length is sampled only when a window opens, so mid-window edits are ignored.
    assign w_len_in  = (win_len == '0) ? LEN_W'(1) : win_len;
    assign w_len_eff = (r_cnt == '0) ? w_len_in : r_len_q;
    assign w_a_next  = ((r_cnt == '0) ? '0 : r_acc) + OUT_W'(r_sum);
    assign w_last    = ({1'b0, r_cnt} + (LEN_W+1)'(1)) == {1'b0, w_len_eff};
    assign w_load    = w_en && r_v2 && w_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_len_q     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_en && r_v2) begin
                if (r_cnt == '0) r_len_q <= w_len_in;
                if (w_last) begin
                    r_out_data <= w_a_next;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_a_next;
                    r_cnt <= r_cnt + LEN_W'(1);
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sumsq_acc.sv
// Bench for sumsq_acc: directed scenarios plus randomized traffic, scored against a
// window-level arithmetic model that predicts each completed window sum.
module tb_sumsq_acc;

    localparam int W     = 12;
    localparam int N     = 4;
    localparam int LEN_W = 8;
    localparam int OUT_W = 2*W + $clog2(N) + LEN_W;

    logic               clk = 1'b0;
    logic               rstn;
    logic               in_valid;
    logic               in_ready;
    logic [N*W-1:0]     in_data;
    logic [LEN_W-1:0]   win_len;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    int               m_cnt = 0;
    int               m_len = 1;
    logic [OUT_W-1:0] m_acc = '0;

    sumsq_acc #(.W(W), .N(N), .LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .win_len(win_len), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        logic [N*W-1:0] d;
        d = '0;
        d[0*W +: W] = W'(c0);
        d[1*W +: W] = W'(c1);
        d[2*W +: W] = W'(c2);
        d[3*W +: W] = W'(c3);
        return d;
    endfunction

    // Reference: a window is win_len samples (0 means 1) counted from its first sample;
    // its result is the plain sum of every channel value squared.
    function automatic void model_accept(input logic [N*W-1:0] d, input logic [LEN_W-1:0] wl);
        logic [OUT_W-1:0] s, c;
        s = '0;
        for (int k = 0; k < N; k++) begin
            c = OUT_W'(d[k*W +: W]);
            s = s + c * c;
        end
        if (m_cnt == 0) begin
            m_len = (wl == 0) ? 1 : int'(wl);
            m_acc = '0;
        end
        m_acc = m_acc + s;
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_q.push_back(m_acc);
            m_cnt = 0;
        end
    endfunction

    // Handshakes seen at the negedge complete on the following rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    check("scoreboard_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) model_accept(in_data, win_len);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        rstn = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic send(input logic [N*W-1:0] d);
        int t;
        t        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("send_timeout", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 60) begin
            tick();
            t++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        repeat (4) tick();
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        win_len   = LEN_W'(1);
        out_ready = 1'b1;
        repeat (2) tick();

        // Full-scale single-sample window and latency
        do_reset();
        win_len = LEN_W'(1);
        send(pack4(4095, 4095, 4095, 4095));
        check("full_lat0_valid", 64'(out_valid), 64'(0));
        tick();
        check("full_lat1_valid", 64'(out_valid), 64'(0));
        tick();
        check("full_lat2_valid", 64'(out_valid), 64'(1));
        check("full_data", 64'(out_data), 64'(67076100));
        drain("full");

        // Three-sample window
        do_reset();
        win_len = LEN_W'(3);
        send(pack4(1, 2, 3, 4));
        send(pack4(1, 2, 3, 4));
        send(pack4(1, 2, 3, 4));
        check("win3_early_valid0", 64'(out_valid), 64'(0));
        tick();
        check("win3_early_valid1", 64'(out_valid), 64'(0));
        tick();
        check("win3_valid", 64'(out_valid), 64'(1));
        check("win3_data", 64'(out_data), 64'(90));
        drain("win3");

        // Back-pressure with a result pending
        do_reset();
        win_len   = LEN_W'(1);
        out_ready = 1'b0;
        send(pack4(2, 0, 0, 0));
        send(pack4(3, 0, 0, 0));
        send(pack4(4, 0, 0, 0));
        in_data  = pack4(7, 7, 7, 7);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out_data", 64'(out_data), 64'(4));
            tick();
        end
        in_valid = 1'b0;
        drain("stall");

        // Window length zero behaves as one
        do_reset();
        win_len = '0;
        send(pack4(0, 0, 0, 5));
        tick();
        tick();
        check("len0_valid", 64'(out_valid), 64'(1));
        check("len0_data", 64'(out_data), 64'(25));
        drain("len0");

        // Reset discards a partial window
        do_reset();
        win_len = LEN_W'(4);
        send(pack4(9, 9, 9, 9));
        send(pack4(9, 9, 9, 9));
        do_reset();
        for (int i = 0; i < 4; i++) send(pack4(1, 1, 1, 1));
        tick();
        tick();
        check("rstmid_valid", 64'(out_valid), 64'(1));
        check("rstmid_data", 64'(out_data), 64'(16));
        drain("rstmid");

        // Mid-window length change is ignored until the next window opens
        do_reset();
        win_len = LEN_W'(2);
        send(pack4(1, 0, 0, 0));
        repeat (3) tick();
        win_len = LEN_W'(5);
        send(pack4(2, 0, 0, 0));
        tick();
        tick();
        check("lenchg_w1_valid", 64'(out_valid), 64'(1));
        check("lenchg_w1_data", 64'(out_data), 64'(5));
        tick();
        for (int i = 0; i < 4; i++) begin
            send(pack4(1, 1, 1, 1));
            check("lenchg_w2_open", 64'(out_valid), 64'(0));
        end
        send(pack4(1, 1, 1, 1));
        tick();
        tick();
        check("lenchg_w2_valid", 64'(out_valid), 64'(1));
        check("lenchg_w2_data", 64'(out_data), 64'(20));
        drain("lenchg");

        // Randomized traffic with random back-pressure
        do_reset();
        for (int blk = 0; blk < 5; blk++) begin
            case ($urandom_range(0, 4))
                0:       win_len = '0;
                1:       win_len = LEN_W'(1);
                2:       win_len = LEN_W'(2);
                3:       win_len = LEN_W'(3);
                default: win_len = LEN_W'(6);
            endcase
            for (int c = 0; c < 250; c++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < N; k++) begin
                    in_data[k*W +: W] = ($urandom_range(0, 7) == 0) ? W'(4095) : W'($urandom_range(0, 4095));
                end
                out_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
            drain("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
